// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I pipeline types: control-bit struct, opcodes, default widths.
package rv_pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RIDX_DEF = 5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // MSB-first order matches the decode control unit's 8-bit output.
  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bus: decode-side inputs, EX-side registered outputs, hold and perf count.
interface id_ex_if import rv_pipe_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int RIDX = RIDX_DEF
);
  logic            id_valid;
  ctrl_t           id_ctrl;
  logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [RIDX-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]      id_funct;
  logic            flush;
  logic            stall_ext;

  logic            ex_valid;
  ctrl_t           ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [RIDX-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct;
  logic            id_hold;
  logic [31:0]     bubble_cnt;

  modport master (
    output id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, flush, stall_ext,
    input  ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, id_hold, bubble_cnt
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc, id_rd1, id_rd2, id_imm,
           id_rs1, id_rs2, id_rd, id_funct, flush, stall_ext,
    output ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, id_hold, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: a load in EX whose rd feeds a source of the ID instruction.
module hazard_detect import rv_pipe_pkg::*; #(
  parameter int RIDX = RIDX_DEF
) (
  input  logic            i_id_valid,
  input  logic            i_id_alusrc,
  input  logic            i_id_memwrite,
  input  logic [RIDX-1:0] i_id_rs1,
  input  logic [RIDX-1:0] i_id_rs2,
  input  logic            i_ex_valid,
  input  logic            i_ex_memread,
  input  logic [RIDX-1:0] i_ex_rd,
  output logic            o_hazard
);
  logic w_uses_rs2;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // I-type and loads carry an immediate in the rs2 field; stores still read rs2.
  assign w_uses_rs2 = !i_id_alusrc | i_id_memwrite;
  assign w_rs1_hit  = (i_ex_rd == i_id_rs1);
  assign w_rs2_hit  = w_uses_rs2 & (i_ex_rd == i_id_rs2);
  assign o_hazard   = i_id_valid & i_ex_valid & i_ex_memread & (i_ex_rd != '0)
                    & (w_rs1_hit | w_rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage register with load-use bubble insertion, flush and downstream hold.
// Optional bubble counter built only when PERF_CNT_EN is defined.
module id_ex_stage import rv_pipe_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int RIDX = RIDX_DEF
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);
  logic            w_hazard;
  logic            w_take;
  logic            r_valid;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_pc, r_rd1, r_rd2, r_imm;
  logic [RIDX-1:0] r_rs1, r_rs2, r_rd;
  logic [3:0]      r_funct;

  hazard_detect #(.RIDX(RIDX)) u_hazard (
    .i_id_valid   (bus.id_valid),
    .i_id_alusrc  (bus.id_ctrl.alusrc),
    .i_id_memwrite(bus.id_ctrl.memwrite),
    .i_id_rs1     (bus.id_rs1),
    .i_id_rs2     (bus.id_rs2),
    .i_ex_valid   (r_valid),
    .i_ex_memread (r_ctrl.memread),
    .i_ex_rd      (r_rd),
    .o_hazard     (w_hazard)
  );

  // Only a real, unkilled, hazard-free instruction may carry control bits into EX.
  assign w_take = bus.id_valid & !bus.flush & !w_hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_funct <= '0;
    end else if (!bus.stall_ext) begin
      r_valid <= w_take;
      r_ctrl  <= w_take ? bus.id_ctrl : '0;
      r_pc    <= bus.id_pc;
      r_rd1   <= bus.id_rd1;
      r_rd2   <= bus.id_rd2;
      r_imm   <= bus.id_imm;
      r_rs1   <= bus.id_rs1;
      r_rs2   <= bus.id_rs2;
      r_rd    <= bus.id_rd;
      r_funct <= bus.id_funct;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_bubble_cnt <= '0;
    else if (!bus.stall_ext && !bus.flush && w_hazard)
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
  end

  assign bus.bubble_cnt = r_bubble_cnt;
`else
  assign bus.bubble_cnt = '0;
`endif

  assign bus.id_hold  = bus.stall_ext | (w_hazard & !bus.flush);
  assign bus.ex_valid = r_valid;
  assign bus.ex_ctrl  = r_ctrl;
  assign bus.ex_pc    = r_pc;
  assign bus.ex_rd1   = r_rd1;
  assign bus.ex_rd2   = r_rd2;
  assign bus.ex_imm   = r_imm;
  assign bus.ex_rs1   = r_rs1;
  assign bus.ex_rs2   = r_rs2;
  assign bus.ex_rd    = r_rd;
  assign bus.ex_funct = r_funct;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use bubbles, flush/stall priority.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  id_ex_if #(.XLEN(32), .RIDX(5)) bus ();

  id_ex_stage #(.XLEN(32), .RIDX(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_bub(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
    bus.id_valid = v;
    bus.id_ctrl  = c;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    bus.id_rd    = rd;
    bus.id_pc    = pc;
    bus.id_rd1   = pc + 32'h1000;
    bus.id_rd2   = pc + 32'h2000;
    bus.id_imm   = pc + 32'h3000;
    bus.id_funct = pc[5:2];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || bus.bubble_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_init: valid=%b ctrl=%h cnt=%h, want 0/00/0", bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt);
    end
    reset = 1'b0;
    drive(1'b1, 8'h22, 5'd1, 5'd2, 5'd3, 32'h40);
    tick();
    tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 8'h22) begin
      fails++;
      $display("FAIL reset_prefill: valid=%b ctrl=%h, want 1/22", bus.ex_valid, bus.ex_ctrl);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || bus.bubble_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_async: valid=%b ctrl=%h cnt=%h, want 0/00/0", bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_rtype;
    drive(1'b1, 8'h22, 5'd3, 5'd4, 5'd6, 32'h100);
    #1;
    tests++;
    if (bus.id_hold !== 1'b0) begin
      fails++;
      $display("FAIL rtype_hold: got %b want 0", bus.id_hold);
    end
    tick();
    tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 8'h22 || bus.ex_rd !== 5'd6 || bus.ex_rs1 !== 5'd3 ||
        bus.ex_rs2 !== 5'd4 || bus.ex_pc !== 32'h100 || bus.ex_rd1 !== 32'h1100 ||
        bus.ex_rd2 !== 32'h2100 || bus.ex_imm !== 32'h3100 || bus.ex_funct !== 4'h0) begin
      fails++;
      $display("FAIL rtype_capture: valid=%b ctrl=%h rd=%0d pc=%h rd1=%h imm=%h, want 1/22/6/100/1100/3100",
               bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.ex_pc, bus.ex_rd1, bus.ex_imm);
    end
  endtask

  task automatic test_load_use;
    drive(1'b1, 8'hF0, 5'd1, 5'd2, 5'd5, 32'h104);
    tick();
    drive(1'b1, 8'hA3, 5'd5, 5'd9, 5'd8, 32'h108);
    #1;
    tests++;
    if (bus.id_hold !== 1'b1) begin
      fails++;
      $display("FAIL lu_hold: got %b want 1", bus.id_hold);
    end
    tick();
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00) begin
      fails++;
      $display("FAIL lu_bubble: valid=%b ctrl=%h, want 0/00", bus.ex_valid, bus.ex_ctrl);
    end
    tests++;
    if (bus.id_hold !== 1'b0) begin
      fails++;
      $display("FAIL lu_release: hold=%b want 0", bus.id_hold);
    end
    tick();
    tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 8'hA3 || bus.ex_pc !== 32'h108) begin
      fails++;
      $display("FAIL lu_capture: valid=%b ctrl=%h pc=%h, want 1/a3/108", bus.ex_valid, bus.ex_ctrl, bus.ex_pc);
    end
    tests++;
    if (bus.bubble_cnt !== exp_bub(1)) begin
      fails++;
      $display("FAIL lu_count: got %0d want %0d", bus.bubble_cnt, exp_bub(1));
    end
  endtask

  task automatic test_rs2;
    drive(1'b1, 8'hF0, 5'd1, 5'd2, 5'd7, 32'h10C);
    tick();
    drive(1'b1, 8'hA3, 5'd1, 5'd7, 5'd9, 32'h110);
    #1;
    tests++;
    if (bus.id_hold !== 1'b0) begin
      fails++;
      $display("FAIL rs2_itype: hold=%b want 0", bus.id_hold);
    end
    drive(1'b1, 8'h88, 5'd1, 5'd7, 5'd0, 32'h110);
    #1;
    tests++;
    if (bus.id_hold !== 1'b1) begin
      fails++;
      $display("FAIL rs2_stype: hold=%b want 1", bus.id_hold);
    end
    tick();
    tests++;
    if (bus.ex_ctrl !== 8'h00 || bus.bubble_cnt !== exp_bub(2)) begin
      fails++;
      $display("FAIL rs2_bubble: ctrl=%h cnt=%0d, want 00/%0d", bus.ex_ctrl, bus.bubble_cnt, exp_bub(2));
    end
    tick();
    tests++;
    if (bus.ex_ctrl !== 8'h88 || bus.ex_valid !== 1'b1) begin
      fails++;
      $display("FAIL rs2_capture: ctrl=%h valid=%b, want 88/1", bus.ex_ctrl, bus.ex_valid);
    end
  endtask

  task automatic test_x0;
    drive(1'b1, 8'hF0, 5'd1, 5'd2, 5'd0, 32'h114);
    tick();
    drive(1'b1, 8'hA3, 5'd0, 5'd0, 5'd4, 32'h118);
    #1;
    tests++;
    if (bus.id_hold !== 1'b0) begin
      fails++;
      $display("FAIL x0_hold: hold=%b want 0", bus.id_hold);
    end
    tick();
    tests++;
    if (bus.ex_ctrl !== 8'hA3 || bus.bubble_cnt !== exp_bub(2)) begin
      fails++;
      $display("FAIL x0_capture: ctrl=%h cnt=%0d, want a3/%0d", bus.ex_ctrl, bus.bubble_cnt, exp_bub(2));
    end
  endtask

  task automatic test_simultaneous;
    drive(1'b1, 8'hF0, 5'd1, 5'd2, 5'd5, 32'h11C);
    tick();
    drive(1'b1, 8'hA3, 5'd5, 5'd0, 5'd6, 32'h120);
    bus.flush = 1'b1;
    #1;
    tests++;
    if (bus.id_hold !== 1'b0) begin
      fails++;
      $display("FAIL flush_hold: hold=%b want 0", bus.id_hold);
    end
    tick();
    bus.flush = 1'b0;
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || bus.bubble_cnt !== exp_bub(2)) begin
      fails++;
      $display("FAIL flush_regs: valid=%b ctrl=%h cnt=%0d, want 0/00/%0d",
               bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, exp_bub(2));
    end
    drive(1'b1, 8'hF0, 5'd1, 5'd2, 5'd5, 32'h124);
    tick();
    drive(1'b1, 8'hA3, 5'd5, 5'd0, 5'd6, 32'h128);
    bus.stall_ext = 1'b1;
    #1;
    tests++;
    if (bus.id_hold !== 1'b1) begin
      fails++;
      $display("FAIL stall_hold: hold=%b want 1", bus.id_hold);
    end
    tick();
    tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 8'hF0 || bus.ex_rd !== 5'd5 ||
        bus.ex_pc !== 32'h124 || bus.bubble_cnt !== exp_bub(2)) begin
      fails++;
      $display("FAIL stall_regs: valid=%b ctrl=%h rd=%0d pc=%h cnt=%0d, want 1/f0/5/124/%0d",
               bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.ex_pc, bus.bubble_cnt, exp_bub(2));
    end
    bus.stall_ext = 1'b0;
    tick();
    tests++;
    if (bus.ex_ctrl !== 8'h00 || bus.bubble_cnt !== exp_bub(3)) begin
      fails++;
      $display("FAIL stall_release: ctrl=%h cnt=%0d, want 00/%0d", bus.ex_ctrl, bus.bubble_cnt, exp_bub(3));
    end
    tick();
    tests++;
    if (bus.ex_ctrl !== 8'hA3 || bus.ex_pc !== 32'h128) begin
      fails++;
      $display("FAIL stall_capture: ctrl=%h pc=%h, want a3/128", bus.ex_ctrl, bus.ex_pc);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 8'hFF, 5'd1, 5'd2, 5'd3, 32'h12C);
    tick();
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00) begin
      fails++;
      $display("FAIL idle_slot: valid=%b ctrl=%h, want 0/00", bus.ex_valid, bus.ex_ctrl);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h22 + 8'(i), 5'd10, 5'd11, 5'd12, 32'h200 + 32'(4 * i));
      tick();
      tests++;
      if (bus.ex_ctrl !== 8'h22 + 8'(i) || bus.ex_pc !== 32'h200 + 32'(4 * i) || bus.ex_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_%0d: ctrl=%h pc=%h valid=%b", i, bus.ex_ctrl, bus.ex_pc, bus.ex_valid);
      end
    end
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.stall_ext = 1'b0;
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    #2;
    test_reset();
    test_rtype();
    test_load_use();
    test_rs2();
    test_x0();
    test_simultaneous();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
